// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: branch opcodes,
// 2-bit counter encodings and a PC increment helper.
package branch_predictor_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BBT = 6'b111111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctrEnc_t;

  // Sequential next PC; the carry out of bit 31 is dropped so the PC wraps.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating counter: counts up on a taken
// outcome, down on not-taken, and holds at 11 and 00.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctrNext
);

  always_comb begin
    ctrNext = ctr;
    if (up) begin
      if (ctr != CTR_ST) ctrNext = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctrNext = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor and BTB: combinational lookup in F,
// resolution and training in D, plus resolved/mispredicted branch counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = CTR_WT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchD,
  input  logic        StallD,
  input  logic [31:0] PCD,
  input  logic        ConditionD,
  input  logic [31:0] BranchTargetD,
  input  logic        PredTakenD,
  input  logic [31:0] PredTargetD,
  output logic        MispredictD,
  output logic [31:0] RedirectPCD,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] validQ;
  logic [TAG_W-1:0] tagQ    [DEPTH];
  logic [1:0]       ctrQ    [DEPTH];
  logic [31:0]      targetQ [DEPTH];

  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;

  logic [IDX_W-1:0] idxD;
  logic [TAG_W-1:0] tagD;
  logic             hitD;
  logic             resolve;
  logic             targetWrong;
  logic [1:0]       ctrNextD;

  // Fetch lookup reads the flops directly, so a same-cycle update is not seen.
  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[31:IDX_W+2];
  assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);

  assign PredTakenF  = hitF & ctrQ[idxF][1];
  assign PredTargetF = PredTakenF ? targetQ[idxF] : pcPlus4(PCF);

  // Reset also masks resolution so no redirect escapes while the table is held.
  assign resolve     = BranchD & ~StallD & rst_n;
  assign targetWrong = PredTargetD != BranchTargetD;
  assign MispredictD = resolve &
                       ((ConditionD != PredTakenD) | (ConditionD & PredTakenD & targetWrong));
  assign RedirectPCD = ConditionD ? BranchTargetD : pcPlus4(PCD);

  assign idxD = PCD[IDX_W+1:2];
  assign tagD = PCD[31:IDX_W+2];
  assign hitD = validQ[idxD] && (tagQ[idxD] == tagD);

  sat_counter2 uSatCounter (
    .ctr     (ctrQ[idxD]),
    .up      (ConditionD),
    .ctrNext (ctrNextD)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int i = 0; i < DEPTH; i++) ctrQ[i] <= CTR_WNT;
    end else if (resolve) begin
      if (hitD) begin
        ctrQ[idxD] <= ctrNextD;
      end else if (ConditionD) begin
        validQ[idxD] <= 1'b1;
        ctrQ[idxD]   <= CNT_INIT;
      end
    end
  end

  // Tag and target are only meaningful behind valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (resolve && ConditionD) begin
      targetQ[idxD] <= BranchTargetD;
      if (!hitD) tagQ[idxD] <= tagD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else if (resolve) begin
      BranchCnt <= BranchCnt + 32'd1;
      if (MispredictD) MispredCnt <= MispredCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run, all checked against a behavioural table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCF = 32'h0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchD = 1'b0;
  logic        StallD = 1'b0;
  logic [31:0] PCD = 32'h0;
  logic        ConditionD = 1'b0;
  logic [31:0] BranchTargetD = 32'h0;
  logic        PredTakenD = 1'b0;
  logic [31:0] PredTargetD = 32'h0;
  logic        MispredictD;
  logic [31:0] RedirectPCD;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int total = 0;
  int bad = 0;

  bit          mValid  [16];
  int          mCtr    [16];
  logic [31:0] mTagPc  [16];
  logic [31:0] mTarget [16];
  logic [31:0] mBr;
  logic [31:0] mMis;
  bit          expMis;
  logic [31:0] expRedir;

  branch_predictor #(.IDX_W(4), .CNT_INIT(2'b10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCF           (PCF),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF),
    .BranchD       (BranchD),
    .StallD        (StallD),
    .PCD           (PCD),
    .ConditionD    (ConditionD),
    .BranchTargetD (BranchTargetD),
    .PredTakenD    (PredTakenD),
    .PredTargetD   (PredTargetD),
    .MispredictD   (MispredictD),
    .RedirectPCD   (RedirectPCD),
    .BranchCnt     (BranchCnt),
    .MispredCnt    (MispredCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int mIdx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit mHit(input logic [31:0] pc);
    int i = mIdx(pc);
    return mValid[i] && (mTagPc[i] == (pc >> 6));
  endfunction

  function automatic bit mPred(input logic [31:0] pc);
    return mHit(pc) && (mCtr[mIdx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] mTgt(input logic [31:0] pc);
    return mPred(pc) ? mTarget[mIdx(pc)] : pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mCtr[i] = 1;
    end
    mBr = 32'd0;
    mMis = 32'd0;
  endtask

  // Drive a decode-stage branch after the falling edge and form expectations.
  task automatic driveD(input bit br, input bit st, input logic [31:0] pcd, input bit cond,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
    @(negedge clk);
    BranchD = br;
    StallD = st;
    PCD = pcd;
    ConditionD = cond;
    BranchTargetD = tgt;
    PredTakenD = pt;
    PredTargetD = ptgt;
    expMis = (br && !st) && ((cond != pt) || (cond && pt && (ptgt != tgt)));
    expRedir = cond ? tgt : pcd + 32'd4;
    #1;
  endtask

  // Clock the resolution in and apply the predictor's training rules to the model.
  task automatic commitD();
    int i;
    @(posedge clk);
    if (BranchD && !StallD && rst_n) begin
      i = mIdx(PCD);
      if (mHit(PCD)) begin
        if (ConditionD) begin
          mCtr[i] = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
          mTarget[i] = BranchTargetD;
        end else begin
          mCtr[i] = (mCtr[i] == 0) ? 0 : mCtr[i] - 1;
        end
      end else if (ConditionD) begin
        mValid[i] = 1'b1;
        mTagPc[i] = PCD >> 6;
        mCtr[i] = 2;
        mTarget[i] = BranchTargetD;
      end
      mBr = mBr + 32'd1;
      if (expMis) mMis = mMis + 32'd1;
    end
    #1;
    BranchD = 1'b0;
    StallD = 1'b0;
  endtask

  task automatic setPcf(input logic [31:0] pc);
    PCF = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    driveD(1'b1, 1'b0, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h0);
    setPcf(32'h00400010);
    total++;
    if (PredTakenF !== 1'b0) begin bad++; $display("FAIL reset_predtaken got=%0b want=0", PredTakenF); end
    total++;
    if (PredTargetF !== 32'h00400014) begin bad++; $display("FAIL reset_predtarget got=%h want=00400014", PredTargetF); end
    total++;
    if (MispredictD !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0b want=0", MispredictD); end
    @(posedge clk);
    #1;
    total++;
    if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", BranchCnt, MispredCnt);
    end
    @(negedge clk);
    BranchD = 1'b0;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_cold_taken();
    driveD(1'b1, 1'b0, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014);
    total++;
    if (MispredictD !== 1'b1) begin bad++; $display("FAIL cold_mispredict got=%0b want=1", MispredictD); end
    total++;
    if (RedirectPCD !== 32'h00400040) begin bad++; $display("FAIL cold_redirect got=%h want=00400040", RedirectPCD); end
    commitD();
    setPcf(32'h00400010);
    total++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h00400040) begin
      bad++; $display("FAIL cold_lookup got=%0b/%h want=1/00400040", PredTakenF, PredTargetF);
    end
    total++;
    if (MispredCnt !== 32'd1 || BranchCnt !== 32'd1) begin
      bad++; $display("FAIL cold_counters got=%0d/%0d want=1/1", BranchCnt, MispredCnt);
    end
  endtask

  task automatic test_saturation();
    bit expPt [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] pc = 32'h00400010;
    for (int k = 0; k < 2; k++) begin
      driveD(1'b1, 1'b0, pc, 1'b1, 32'h00400040, mPred(pc), mTgt(pc));
      total++;
      if (MispredictD !== 1'b0) begin bad++; $display("FAIL sat_up_mispredict step=%0d got=%0b want=0", k, MispredictD); end
      commitD();
    end
    for (int k = 0; k < 3; k++) begin
      driveD(1'b1, 1'b0, pc, 1'b0, 32'h00400040, mPred(pc), mTgt(pc));
      total++;
      if (MispredictD !== expMis || RedirectPCD !== 32'h00400014) begin
        bad++; $display("FAIL sat_dn_resolve step=%0d got=%0b/%h want=%0b/00400014", k, MispredictD, RedirectPCD, expMis);
      end
      commitD();
      setPcf(pc);
      total++;
      if (PredTakenF !== expPt[k] || PredTakenF !== mPred(pc)) begin
        bad++; $display("FAIL sat_dn_lookup step=%0d got=%0b want=%0b", k, PredTakenF, expPt[k]);
      end
    end
  endtask

  task automatic test_target_change();
    logic [31:0] pc = 32'h00400010;
    for (int k = 0; k < 2; k++) begin
      driveD(1'b1, 1'b0, pc, 1'b1, 32'h00400040, mPred(pc), mTgt(pc));
      commitD();
    end
    setPcf(pc);
    total++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h00400040) begin
      bad++; $display("FAIL tgt_before got=%0b/%h want=1/00400040", PredTakenF, PredTargetF);
    end
    driveD(1'b1, 1'b0, pc, 1'b1, 32'h00400080, 1'b1, 32'h00400040);
    total++;
    if (MispredictD !== 1'b1 || RedirectPCD !== 32'h00400080) begin
      bad++; $display("FAIL tgt_resolve got=%0b/%h want=1/00400080", MispredictD, RedirectPCD);
    end
    commitD();
    setPcf(pc);
    total++;
    if (PredTargetF !== 32'h00400080) begin bad++; $display("FAIL tgt_after got=%h want=00400080", PredTargetF); end
  endtask

  task automatic test_alias();
    driveD(1'b1, 1'b0, 32'h00400050, 1'b1, 32'h00400100, mPred(32'h00400050), mTgt(32'h00400050));
    // Same-index lookup in the training cycle still sees the old entry.
    setPcf(32'h00400010);
    total++;
    if (PredTakenF !== mPred(32'h00400010) || PredTargetF !== mTgt(32'h00400010)) begin
      bad++; $display("FAIL alias_nobypass got=%0b/%h want=%0b/%h", PredTakenF, PredTargetF,
                      mPred(32'h00400010), mTgt(32'h00400010));
    end
    commitD();
    setPcf(32'h00400010);
    total++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h00400014) begin
      bad++; $display("FAIL alias_old_miss got=%0b/%h want=0/00400014", PredTakenF, PredTargetF);
    end
    setPcf(32'h00400050);
    total++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h00400100) begin
      bad++; $display("FAIL alias_new_hit got=%0b/%h want=1/00400100", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_stall();
    logic [31:0] br0 = mBr;
    logic [31:0] mis0 = mMis;
    for (int k = 0; k < 3; k++) begin
      driveD(1'b1, 1'b1, 32'h00400030, 1'b1, 32'h00400200, 1'b0, 32'h00400034);
      total++;
      if (MispredictD !== 1'b0) begin bad++; $display("FAIL stall_mispredict cycle=%0d got=%0b want=0", k, MispredictD); end
      commitD();
      total++;
      if (BranchCnt !== br0 || MispredCnt !== mis0) begin
        bad++; $display("FAIL stall_counters cycle=%0d got=%0d/%0d want=%0d/%0d", k, BranchCnt, MispredCnt, br0, mis0);
      end
    end
    setPcf(32'h00400030);
    total++;
    if (PredTakenF !== 1'b0) begin bad++; $display("FAIL stall_no_train got=%0b want=0", PredTakenF); end
    driveD(1'b1, 1'b0, 32'h00400030, 1'b1, 32'h00400200, 1'b0, 32'h00400034);
    total++;
    if (MispredictD !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b want=1", MispredictD); end
    commitD();
    total++;
    if (BranchCnt !== br0 + 32'd1 || MispredCnt !== mis0 + 32'd1) begin
      bad++; $display("FAIL stall_once got=%0d/%0d want=%0d/%0d", BranchCnt, MispredCnt, br0 + 32'd1, mis0 + 32'd1);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'h00400010, 32'h00400050, 32'h00400020,
                              32'h00401020, 32'h00400ffc, 32'hfffffffc};
    logic [31:0] pcd, pcf, tgt, ptgt;
    bit br, st, cond;
    for (int n = 0; n < 300; n++) begin
      pcd = pool[$urandom_range(5)];
      pcf = pool[$urandom_range(5)];
      br = ($urandom_range(3) != 0);
      st = ($urandom_range(3) == 0);
      cond = $urandom_range(1) == 1;
      tgt = ($urandom_range(2) == 0) ? mTarget[mIdx(pcd)] : ($urandom & 32'hfffffffc);
      ptgt = mTgt(pcd);
      if ($urandom_range(7) == 0) ptgt = ptgt ^ 32'h00000100;
      driveD(br, st, pcd, cond, tgt, mPred(pcd), ptgt);
      setPcf(pcf);
      total++;
      if (MispredictD !== expMis || (expMis && RedirectPCD !== expRedir)) begin
        bad++; $display("FAIL rand_resolve n=%0d got=%0b/%h want=%0b/%h", n, MispredictD, RedirectPCD, expMis, expRedir);
      end
      total++;
      if (PredTakenF !== mPred(pcf) || PredTargetF !== mTgt(pcf)) begin
        bad++; $display("FAIL rand_lookup n=%0d pc=%h got=%0b/%h want=%0b/%h", n, pcf, PredTakenF, PredTargetF,
                        mPred(pcf), mTgt(pcf));
      end
      commitD();
      total++;
      if (BranchCnt !== mBr || MispredCnt !== mMis) begin
        bad++; $display("FAIL rand_counters n=%0d got=%0d/%0d want=%0d/%0d", n, BranchCnt, MispredCnt, mBr, mMis);
      end
    end
  endtask

  task automatic test_async_reset();
    driveD(1'b1, 1'b0, 32'h00400060, 1'b1, 32'h00400300, 1'b0, 32'h00400064);
    commitD();
    setPcf(32'h00400060);
    total++;
    if (PredTakenF !== 1'b1) begin bad++; $display("FAIL areset_pretrained got=%0b want=1", PredTakenF); end
    // Start a new training and drop reset before the edge that would commit it.
    driveD(1'b1, 1'b0, 32'h00400024, 1'b1, 32'h00400400, 1'b0, 32'h00400028);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h00400064) begin
      bad++; $display("FAIL areset_lookup got=%0b/%h want=0/00400064", PredTakenF, PredTargetF);
    end
    total++;
    if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0 || MispredictD !== 1'b0) begin
      bad++; $display("FAIL areset_outputs got=%0d/%0d/%0b want=0/0/0", BranchCnt, MispredCnt, MispredictD);
    end
    @(posedge clk);
    @(negedge clk);
    BranchD = 1'b0;
    rst_n = 1'b1;
    modelReset();
    #1;
    setPcf(32'h00400024);
    total++;
    if (PredTakenF !== 1'b0) begin bad++; $display("FAIL areset_discarded got=%0b want=0", PredTakenF); end
    setPcf(32'h00400050);
    total++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h00400054) begin
      bad++; $display("FAIL areset_old_miss got=%0b/%h want=0/00400054", PredTakenF, PredTargetF);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_cold_taken();
    test_saturation();
    test_target_change();
    test_alias();
    test_stall();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and BTB.
- Supplies the speculative taken/target guess in F for branches (beq opcode 000100, bbt opcode 111111).
- Consumes the decode-stage resolution (ConditionD, computed branch target) to train the table.
- Raises a mispredict redirect back to the PC mux.
- Sits between the PC register/fetch mux and the decode-stage branch condition logic.

Parameters:
- IDX_W, 4, index bits; table depth = 2**IDX_W entries, direct-mapped, indexed by PC[IDX_W+1:2].
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCF  in  32  fetch PC.
- PredTakenF  out  1  predicted taken for PCF.
- PredTargetF  out  32  predicted target; PCF+4 when not predicted taken.
- BranchD  in  1  decode holds a valid conditional branch.
- StallD  in  1  decode stalled; no training this cycle.
- PCD  in  32  PC of the decode instruction.
- ConditionD  in  1  resolved branch outcome from decode.
- BranchTargetD  in  32  computed branch target in D.
- PredTakenD  in  1  PredTakenF piped to D.
- PredTargetD  in  32  PredTargetF piped to D.
- MispredictD  out  1  flush F and redirect PC.
- RedirectPCD  out  32  correct next PC.
- BranchCnt  out  32  resolved-branch counter.
- MispredCnt  out  32  mispredict counter.

Behaviour:
- Entry fields: valid(1), tag(32-IDX_W-2 = PC[31:IDX_W+2]), ctr(2), target(32).
- Lookup is combinational from PCF, with no added latency.
  - hit = valid & tag match.
  - PredTakenF = hit & ctr[1].
  - PredTargetF = PredTakenF ? target : PCF+4.
- Resolution is combinational in D, qualified by BranchD & !StallD; call this resolve.
- MispredictD = resolve & ((ConditionD != PredTakenD) | (ConditionD & PredTakenD & PredTargetD != BranchTargetD)).
- RedirectPCD = ConditionD ? BranchTargetD : PCD+4. It is driven every cycle and is meaningful only when MispredictD=1.
- When resolve=0, MispredictD=0.
- Training happens on the rising edge when resolve=1, using the PCD index/tag:
  - Hit, taken: ctr saturating increment (11 stays 11); target <= BranchTargetD.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid=1, tag, ctr=CNT_INIT, target=BranchTargetD. Any aliasing entry is overwritten.
  - Miss, not taken: no allocation, table unchanged.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents (no bypass). The update is visible from the next cycle.
- StallD=1 with BranchD=1: no training, no counter increment, MispredictD=0. Resolution repeats once the stall releases, so it is counted exactly once.
- Perf counters, when resolve=1:
  - BranchCnt += 1.
  - MispredCnt += 1 if MispredictD.
  - Both wrap modulo 2**32.
- Reset (async, rst_n=0): all valid=0, all ctr=2'b01, targets and tags don't-care.
  - Outputs under reset: BranchCnt=0, MispredCnt=0, PredTakenF=0, PredTargetF=PCF+4, MispredictD=0.
  - Reset asserted mid-training discards that update.
  - Deassertion is synchronised externally; no special first-cycle behaviour.
- Adders are 32-bit; carry out of PC+4 is ignored (wrap).

Decomposition:
- Shared package holds:
  - Opcode constants OP_BEQ=6'b000100 and OP_BBT=6'b111111 (used by branch-condition logic and BranchD generation upstream).
  - Counter encodings CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
- One natural sub-module: sat_counter2, holding 2-bit saturating increment/decrement logic (combinational next-value function), instantiated once on the update path.
- The table is flop-based register arrays. No RAM macro: the read is asynchronous.

Test Plan:
- Reset then lookup PCF=0x00400010 -> PredTakenF=0, PredTargetF=0x00400014; BranchCnt=MispredCnt=0.
- Cold taken branch:
  - Stimulus: PCD=0x00400010, BranchD=1, ConditionD=1, BranchTargetD=0x00400040, PredTakenD=0.
  - Response: MispredictD=1, RedirectPCD=0x00400040.
  - Next cycle, PCF=0x00400010 -> PredTakenF=1, PredTargetF=0x00400040; MispredCnt=1.
- Counter saturation at the same PC:
  - Two more taken resolutions -> ctr=11.
  - Then three not-taken resolutions: PredTakenF stays 1 after the first (ctr 10); 0 after the second and third (ctr 01 -> 00).
- Target change: entry predicts 0x00400040 with PredTakenD=1, ConditionD=1, BranchTargetD=0x00400080 -> MispredictD=1, RedirectPCD=0x00400080; entry target updated.
- Alias and stall:
  - PCD=0x00400050 (same index as 0x00400010, IDX_W=4) taken -> replaces the entry; lookup of 0x00400010 then misses.
  - BranchD=1 with StallD=1 for 3 cycles -> no MispredictD, counters unchanged; counted once after release.
- Async reset mid-run: drop rst_n between clock edges -> PredTakenF=0 and counters=0 immediately; previously trained PCs miss.
